sync_fifo_param: RTL and testbench

Single-clock, parametrised successor to the team's asynchronous FIFO. Intended for same-domain buffering.
- Generalised data width and depth; depth need not be a power of two.
- Selectable read mode: standard registered read, or first-word-fall-through (FWFT).
- Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 16 +
 rtl/sync_fifo_param.sv | 82 ++++++++
 tb/tb_sync_fifo_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and width helpers shared by the sync FIFO
package fifo_pkg;
  localparam int MODE_STD = 0;
  localparam int MODE_FWFT = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int CW(input int depth);
    return clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module fifo_mem import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [clog2(DEPTH)-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [clog2(DEPTH)-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO, any depth, standard or FWFT read, level and sticky error flags
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT = MODE_STD,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   r_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [CW(DEPTH)-1:0]   count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);
  localparam int AW = clog2(DEPTH);
  localparam int CNT_W = CW(DEPTH);
  if (DEPTH < 2 || DEPTH > 4096 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH ||
      (FWFT != MODE_STD && FWFT != MODE_FWFT)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/FWFT/AF_LEVEL/AE_LEVEL");
  end
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, rd_data;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wr_acc, rd_acc;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count_q == CNT_W'(DEPTH);
  assign empty = count_q == '0;
  assign almost_full = count_q >= CNT_W'(AF_LEVEL);
  assign almost_empty = count_q <= CNT_W'(AE_LEVEL);
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;
  always_comb begin
    wr_ptr_d = wr_acc ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? inc(rd_ptr_q) : rd_ptr_q;
    count_d = (wr_acc & ~rd_acc) ? count_q + 1'b1 : (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
    dout_d = rd_acc ? rd_data : dout_q;
    ovf_d = (w_en & full) | (ovf_q & ~clr_err);
    unf_d = (r_en & empty) | (unf_q & ~clr_err);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      dout_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      dout_q <= dout_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we_i(wr_acc & ~rst),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_in),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );
  // FWFT output is forced to zero while empty so reset and idle read back as 0
  assign data_out = (FWFT == MODE_FWFT) ? (empty ? '0 : rd_data) : dout_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for a standard-read DEPTH=8 FIFO and an FWFT DEPTH=5 FIFO
module tb_sync_fifo_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_rst = 1'b1, a_w = 1'b0, a_r = 1'b0, a_clr = 1'b0;
  logic [7:0] a_din = '0, a_dout;
  logic a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_cnt;
  logic b_rst = 1'b1, b_w = 1'b0, b_r = 1'b0, b_clr = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
    .clk(clk), .rst(a_rst), .w_en(a_w), .data_in(a_din), .r_en(a_r), .data_out(a_dout),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_unf), .clr_err(a_clr)
  );
  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
    .clk(clk), .rst(b_rst), .w_en(b_w), .data_in(b_din), .r_en(b_r), .data_out(b_dout),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic a_cyc(input logic w, input logic [7:0] d, input logic r, input logic c, input logic push);
    a_w = w; a_din = d; a_r = r; a_clr = c;
    if (push) qa.push_back(d);
    @(posedge clk); #1;
  endtask
  task automatic b_cyc(input logic w, input logic [7:0] d, input logic r, input logic push);
    b_w = w; b_din = d; b_r = r; b_clr = 1'b0;
    if (push) qb.push_back(d);
    @(posedge clk); #1;
  endtask
  initial begin
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_sb_underrun: got read data 0x%0h, expected no data", a_dout);
        end else chk("a_rd_data", a_dout, qa.pop_front());
      end
      pend = a_r & ~a_empty & ~a_rst;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (b_r && !b_empty && !b_rst) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_sb_underrun: got head 0x%0h, expected no data", b_dout);
        end else chk("b_head", b_dout, qb.pop_front());
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    chk("a_rst_count", a_cnt, 0);
    chk("a_rst_empty", a_empty, 1);
    a_cyc(0, 8'h00, 1, 0, 0);
    chk("a_early_underflow", a_unf, 1);
    for (int i = 1; i <= 3; i++) a_cyc(1, 8'h60 + 8'(i), 0, 0, 1);
    chk("a_pre_rst_count", a_cnt, 3);
    a_rst = 1'b1; a_w = 1'b1; a_din = 8'hEE; a_r = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_rst = 1'b0; a_w = 1'b0; a_r = 1'b0;
    qa.delete();
    chk("t1_count", a_cnt, 0);
    chk("t1_empty", a_empty, 1);
    chk("t1_ae", a_ae, 1);
    chk("t1_full", a_full, 0);
    chk("t1_af", a_af, 0);
    chk("t1_ovf", a_ovf, 0);
    chk("t1_unf", a_unf, 0);
    chk("t1_dout", a_dout, 0);
    for (int i = 1; i <= 8; i++) begin
      a_cyc(1, 8'(i), 0, 0, 1);
      chk($sformatf("t2_count_%0d", i), a_cnt, i);
      chk($sformatf("t2_full_%0d", i), a_full, i == 8);
      chk($sformatf("t2_af_%0d", i), a_af, i >= 6);
      chk($sformatf("t2_ae_%0d", i), a_ae, i <= 2);
    end
    chk("t2_dout_no_read", a_dout, 0);
    a_cyc(1, 8'hFF, 0, 0, 0);
    chk("t2_full_after_9th", a_full, 1);
    chk("t2_count_after_9th", a_cnt, 8);
    chk("t2_overflow", a_ovf, 1);
    chk("t2_underflow", a_unf, 0);
    a_cyc(0, 8'h00, 0, 1, 0);
    chk("t6_clear", a_ovf, 0);
    a_cyc(1, 8'hFF, 0, 1, 0);
    chk("t6_err_wins", a_ovf, 1);
    a_cyc(0, 8'h00, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      a_cyc(0, 8'h00, 1, 0, 0);
      chk($sformatf("t3_dout_%0d", i), a_dout, i);
      chk($sformatf("t3_count_%0d", i), a_cnt, 8 - i);
    end
    chk("t3_empty", a_empty, 1);
    a_cyc(0, 8'h00, 1, 0, 0);
    chk("t3_underflow", a_unf, 1);
    chk("t3_dout_hold", a_dout, 8'h08);
    a_cyc(0, 8'h00, 0, 1, 0);
    for (int i = 1; i <= 8; i++) a_cyc(1, 8'h10 + 8'(i), 0, 0, 1);
    chk("t5_full", a_full, 1);
    a_cyc(1, 8'h55, 1, 0, 0);
    chk("t5_full_rw_count", a_cnt, 7);
    chk("t5_full_rw_ovf", a_ovf, 1);
    chk("t5_full_rw_dout", a_dout, 8'h11);
    repeat (4) a_cyc(0, 8'h00, 1, 0, 0);
    chk("t5_count3", a_cnt, 3);
    a_cyc(1, 8'h19, 1, 0, 1);
    chk("t5_rw_count3", a_cnt, 3);
    repeat (3) a_cyc(0, 8'h00, 1, 0, 0);
    chk("t5_drained", a_empty, 1);
    a_cyc(0, 8'h00, 0, 1, 0);
    chk("t5_unf_cleared", a_unf, 0);
    a_cyc(1, 8'h20, 1, 0, 1);
    chk("t5_empty_rw_count", a_cnt, 1);
    chk("t5_empty_rw_unf", a_unf, 1);
    a_cyc(0, 8'h00, 1, 0, 0);
    a_cyc(0, 8'h00, 0, 0, 0);
    chk("a_sb_leftover", qa.size(), 0);
    b_rst = 1'b0;
    @(posedge clk); #1;
    chk("b_rst_empty", b_empty, 1);
    chk("b_rst_dout", b_dout, 0);
    chk("b_rst_count", b_cnt, 0);
    b_cyc(1, 8'hA5, 0, 1);
    b_r = 1'b0; b_w = 1'b0;
    chk("t4_empty", b_empty, 0);
    chk("t4_dout", b_dout, 8'hA5);
    chk("t4_count", b_cnt, 1);
    for (int i = 0; i < 3; i++) b_cyc(1, 8'hB0 + 8'(i), 0, 1);
    chk("t4_count4", b_cnt, 4);
    chk("t4_af", b_af, 1);
    chk("t4_ae", b_ae, 0);
    for (int i = 0; i < 12; i++) b_cyc(1, 8'hC0 + 8'(i), 1, 1);
    chk("t4_stream_count", b_cnt, 4);
    repeat (4) b_cyc(0, 8'h00, 1, 0);
    chk("t4_drain_empty", b_empty, 1);
    for (int i = 0; i < 5; i++) b_cyc(1, 8'hD0 + 8'(i), 0, 1);
    chk("t4_full", b_full, 1);
    chk("t4_full_count", b_cnt, 5);
    b_cyc(1, 8'hEE, 0, 0);
    chk("t4_overflow", b_ovf, 1);
    repeat (5) b_cyc(0, 8'h00, 1, 0);
    b_cyc(0, 8'h00, 0, 0);
    chk("t4_final_empty", b_empty, 1);
    chk("b_sb_leftover", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
